generador_ventana_pixeles: RTL
==============================

Name: generador_ventana_pixeles

Overview:
- Streaming window generator that acts as the producer side of the convolution window interface.
- Accepts a raster-order 8-bit pixel stream and builds a 3x3 or 5x5 window with internal line buffers.
- Presents the window as a flat 25-pixel bus and pulses ventana_pixeles_lista.
- Stalls input until the convolution engine returns pixel_calculado; one window is in flight at a time.

Parameters:
BITS_PIXEL, 8, pixel width
BITS_MASCARA, 3, width of tamano_mascara
MAX_ANCHO, 640, maximum image width; line buffer depth
BITS_DIM, 10, width of ancho_imagen/alto_imagen and position counters

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
inicio  input  1  one-cycle pulse; latches dimensions and mask size, starts a frame
tamano_mascara  input  BITS_MASCARA  mask size; 3 or 5 (any other value treated as 3)
ancho_imagen  input  BITS_DIM  image width in pixels, K..MAX_ANCHO
alto_imagen  input  BITS_DIM  image height in pixels, >=K
pixel_entrada  input  BITS_PIXEL  incoming pixel, raster order
pixel_valido  input  1  pixel_entrada valid
pixel_listo  output  1  block can accept a pixel; transfer = pixel_valido & pixel_listo at posedge
pixel_calculado  input  1  convolution done with current window
ventana_pixeles  output  25*BITS_PIXEL  pixel_value_1 at bits [7:0] ... pixel_value_25 at [199:192], row-major
ventana_pixeles_lista  output  1  one-cycle window-ready pulse
imagen_completa  output  1  one-cycle pulse after the last window of the frame is acknowledged

Behaviour:
- Reset (reset=0):
  - State is REPOSO; counters are 0.
  - pixel_listo=0, ventana_pixeles=0, ventana_pixeles_lista=0, imagen_completa=0.
  - Line buffer contents are don't-care.
- K=5 when the latched tamano_mascara==5, otherwise K=3.
- State REPOSO: pixel_listo=0. On inicio, latch ancho/alto/K, clear col and fila, and go to LLENANDO.
- State LLENANDO: pixel_listo=1. Each transfer does the following:
  - Writes the pixel into the line buffers and K x K shift register at column col.
  - Advances col; when col wraps from ancho-1 to 0, fila increments.
  - Pixels with col>=K-1 and fila>=K-1 complete a window. On that edge, capture the window into ventana_pixeles and go to EMITIR.
  - For a window, element (r,c) with r,c in 0..K-1 equals pixel at (fila-K+1+r, col-K+1+c).
  - For K=3, elements map to pixel_value_1..9 row-major and pixel_value_10..25 are driven to 0.
  - For K=5, elements map to pixel_value_1..25.
  - No padding: border positions produce no window. Windows per frame = (ancho-K+1)*(alto-K+1).
- State EMITIR (1 cycle): ventana_pixeles_lista=1, pixel_listo=0, then go to ESPERA.
- State ESPERA: pixel_listo=0, and ventana_pixeles is held stable.
  - On pixel_calculado=1: if this was the last pixel of the frame, go to FIN; otherwise go to LLENANDO.
- State FIN (1 cycle): imagen_completa=1, then go to REPOSO.
- pixel_calculado is ignored outside ESPERA.
- inicio is ignored outside REPOSO.
- Latency: the window-completing pixel is accepted at edge N; ventana_pixeles_lista is high during cycle N+1.
- Row wrap and the last pixel of a row complete correctly. The shift register reloads from the line buffers at each new row, with no stale columns from the previous row.
- Reset asserted mid-frame aborts immediately. The next frame requires inicio and must not emit windows containing pre-reset data.

Optional Feature:
- Macro: GENERADOR_VENTANA_CONTADOR_EN.
- When defined, add output ventanas_emitidas [BITS_DIM*2-1:0]:
  - Cleared by reset and by inicio.
  - Increments on each ventana_pixeles_lista pulse.
  - Holds its value after imagen_completa.
- When not defined, the port and counter do not exist and behaviour is otherwise identical.

Test Plan:
- 4x4 image, K=3, pixels 1..16 streamed continuously, pixel_calculado returned 2 cycles after each lista:
  - 4 windows in order; first window = 1,2,3,5,6,7,9,10,11 with values 10..25 = 0; last window = 6,7,8,10,11,12,14,15,16.
  - imagen_completa pulses once, after the 4th acknowledgement.
- 5x5 image, K=5 (tamano_mascara=5), pixels 1..25 -> exactly one window, ventana_pixeles = 1..25 in order; lista high exactly one cycle, in the cycle after pixel 25 is accepted.
- Backpressure: with the 4x4/K=3 stream, delay pixel_calculado by 7 cycles:
  - pixel_listo stays 0 from EMITIR until the edge that samples pixel_calculado.
  - ventana_pixeles is unchanged throughout; no pixel is lost or duplicated.
- Spurious inputs:
  - pixel_calculado pulsed during LLENANDO, and inicio pulsed mid-frame, have no effect.
  - pixel_valido toggling 1/0 every cycle still yields the same 4 windows as the first scenario.
- Reset mid-frame: assert reset=0 after pixel 9 of the first scenario, release it, then restart with inicio:
  - Outputs are 0 during reset.
  - Re-streaming 1..16 gives a first window of 1,2,3,5,6,7,9,10,11.
- With GENERADOR_VENTANA_CONTADOR_EN defined, a 6x5 image with K=3 gives ventanas_emitidas=12 at imagen_completa.

Source files
------------

// File: rtl/generador_ventana_pixeles.sv
// Raster pixel stream -> 3x3/5x5 window via line buffers; GENERADOR_VENTANA_CONTADOR_EN adds ventanas_emitidas.
// Latency: window-completing pixel accepted at edge N, ventana_pixeles_lista high during cycle N+1.
// Backpressure: pixel_listo low from window capture until pixel_calculado is seen; one window in flight.
module generador_ventana_pixeles #(
   parameter int BITS_PIXEL   = 8,
   parameter int BITS_MASCARA = 3,
   parameter int MAX_ANCHO    = 640,
   parameter int BITS_DIM     = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     inicio,
   input  logic [BITS_MASCARA-1:0]  tamano_mascara,
   input  logic [BITS_DIM-1:0]      ancho_imagen,
   input  logic [BITS_DIM-1:0]      alto_imagen,
   input  logic [BITS_PIXEL-1:0]    pixel_entrada,
   input  logic                     pixel_valido,
   output logic                     pixel_listo,
   input  logic                     pixel_calculado,
   output logic [25*BITS_PIXEL-1:0] ventana_pixeles,
   output logic                     ventana_pixeles_lista,
   output logic                     imagen_completa
`ifdef GENERADOR_VENTANA_CONTADOR_EN
   ,
   output logic [BITS_DIM*2-1:0]    ventanas_emitidas
`endif
);

   localparam logic [2:0] REPOSO   = 3'd0;
   localparam logic [2:0] LLENANDO = 3'd1;
   localparam logic [2:0] EMITIR   = 3'd2;
   localparam logic [2:0] ESPERA   = 3'd3;
   localparam logic [2:0] FIN      = 3'd4;

   logic [2:0]          estado;
   logic [BITS_DIM-1:0] ancho;
   logic [BITS_DIM-1:0] alto;
   logic                es_k5;
   logic [BITS_DIM-1:0] col;
   logic [BITS_DIM-1:0] fila;
   logic                ultimo;

   logic [BITS_DIM-1:0] k_menos_1;
   logic                transferencia;
   logic                fin_fila;
   logic                completa;

   // linea[i] holds row fila-1-i at each column
   logic [BITS_PIXEL-1:0] linea [4][MAX_ANCHO];
   logic [BITS_PIXEL-1:0] sr [5][5];
   logic [BITS_PIXEL-1:0] sr_sig [5][5];
   logic [BITS_PIXEL-1:0] col_nueva [5];
   logic [25*BITS_PIXEL-1:0] ventana_sig;

   assign k_menos_1     = es_k5 ? BITS_DIM'(4) : BITS_DIM'(2);
   assign transferencia = pixel_valido && (estado == LLENANDO);
   assign fin_fila      = (col == ancho - BITS_DIM'(1));
   assign completa      = transferencia && (col >= k_menos_1) && (fila >= k_menos_1);

   assign pixel_listo           = (estado == LLENANDO);
   assign ventana_pixeles_lista = (estado == EMITIR);
   assign imagen_completa       = (estado == FIN);

   // Newest column of the window, oldest row first; the live pixel is the bottom row
   always_comb begin
      col_nueva = '{default: '0};
      if (es_k5) begin
         col_nueva[0] = linea[3][col];
         col_nueva[1] = linea[2][col];
         col_nueva[2] = linea[1][col];
         col_nueva[3] = linea[0][col];
         col_nueva[4] = pixel_entrada;
      end else begin
         col_nueva[0] = linea[1][col];
         col_nueva[1] = linea[0][col];
         col_nueva[2] = pixel_entrada;
      end
   end

   always_comb begin
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 4; c++) begin
            sr_sig[r][c] = sr[r][c+1];
         end
         sr_sig[r][4] = col_nueva[r];
      end
   end

   // K=3 uses the three rightmost shift-register columns
   always_comb begin
      ventana_sig = '0;
      if (es_k5) begin
         for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
               ventana_sig[(r*5+c)*BITS_PIXEL +: BITS_PIXEL] = sr_sig[r][c];
            end
         end
      end else begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               ventana_sig[(r*3+c)*BITS_PIXEL +: BITS_PIXEL] = sr_sig[r][c+2];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (transferencia) begin
         linea[0][col] <= pixel_entrada;
         for (int i = 1; i < 4; i++) begin
            linea[i][col] <= linea[i-1][col];
         end
         sr <= sr_sig;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado          <= REPOSO;
         ancho           <= '0;
         alto            <= '0;
         es_k5           <= 1'b0;
         col             <= '0;
         fila            <= '0;
         ultimo          <= 1'b0;
         ventana_pixeles <= '0;
      end else begin
         case (estado)
            REPOSO: begin
               if (inicio) begin
                  ancho  <= ancho_imagen;
                  alto   <= alto_imagen;
                  es_k5  <= (tamano_mascara == BITS_MASCARA'(5));
                  col    <= '0;
                  fila   <= '0;
                  estado <= LLENANDO;
               end
            end
            LLENANDO: begin
               if (transferencia) begin
                  if (fin_fila) begin
                     col  <= '0;
                     fila <= fila + BITS_DIM'(1);
                  end else begin
                     col <= col + BITS_DIM'(1);
                  end
                  if (completa) begin
                     ventana_pixeles <= ventana_sig;
                     ultimo          <= fin_fila && (fila == alto - BITS_DIM'(1));
                     estado          <= EMITIR;
                  end
               end
            end
            EMITIR:  estado <= ESPERA;
            ESPERA: begin
               if (pixel_calculado) begin
                  estado <= ultimo ? FIN : LLENANDO;
               end
            end
            FIN:     estado <= REPOSO;
            default: estado <= REPOSO;
         endcase
      end
   end

`ifdef GENERADOR_VENTANA_CONTADOR_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ventanas_emitidas <= '0;
      end else if (estado == REPOSO && inicio) begin
         ventanas_emitidas <= '0;
      end else if (estado == EMITIR) begin
         ventanas_emitidas <= ventanas_emitidas + (BITS_DIM*2)'(1);
      end
   end
`endif

endmodule
